// File: rtl/nand_vector_sequencer.sv
// Exhaustive self-test sequencer for a WIDTH-bit bitwise Nand array: drives every operand pair,
// waits SETTLE cycles, checks gate_out. Optional first-mismatch capture: FIRST_FAIL_CAPTURE_EN.
module nand_vector_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH-1:0]     gate_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   fail_vec,
    output logic                 fail_valid
);

    localparam int IW          = 2 * WIDTH;
    localparam int CW          = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   settle_cnt;
    logic            mismatch;

    // Only meaningful in CHECK; gate_out may be X elsewhere.
    assign mismatch = (gate_out != ~(op_a & op_b));

`ifdef FIRST_FAIL_CAPTURE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (state == ST_CHECK && mismatch && !fail_valid) begin
            fail_vec   <= {op_a, op_b};
            fail_valid <= 1'b1;
        end
    end
`else
    assign fail_vec   = '0;
    assign fail_valid = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err_count <= '0;
                        pass      <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    op_a       <= idx[IW-1:WIDTH];
                    op_b       <= idx[WIDTH-1:0];
                    settle_cnt <= CW'(SETTLE_LOAD);
                    state      <= (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0)
                        state <= ST_CHECK;
                    else
                        settle_cnt <= settle_cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch)
                        err_count <= err_count + 1'b1;
                    if (&idx) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    // err_count is final here; the last CHECK update has landed.
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_vector_sequencer.sv
// Randomized bench: two sequencers (SETTLE=2 and SETTLE=0) against a fault-injecting Nand model.
module tb_nand_vector_sequencer;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]            start = '0;
    logic [1:0][W-1:0]     op_a_w, op_b_w, gate_w;
    logic [1:0]            busy_w, done_w, pass_w, fvalid_w;
    logic [1:0][2*W:0]     errc_w;
    logic [1:0][2*W-1:0]   fvec_w;

    logic [1:0][W-1:0]     sa0 = '0, sa1 = '0;
    logic [W-1:0]          corr0 [N];
    logic [W-1:0]          corr1 [N];

    int n_chk = 0;
    int n_pass = 0;

    nand_vector_sequencer #(.WIDTH(W), .SETTLE(2)) dut0 (
        .clk(clk), .reset(rst), .start(start[0]), .op_a(op_a_w[0]), .op_b(op_b_w[0]),
        .gate_out(gate_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(errc_w[0]), .fail_vec(fvec_w[0]), .fail_valid(fvalid_w[0]));

    nand_vector_sequencer #(.WIDTH(W), .SETTLE(0)) dut1 (
        .clk(clk), .reset(rst), .start(start[1]), .op_a(op_a_w[1]), .op_b(op_b_w[1]),
        .gate_out(gate_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(errc_w[1]), .fail_vec(fvec_w[1]), .fail_valid(fvalid_w[1]));

    // Faulty Nand array: stuck-at masks plus a per-vector flip table.
    always_comb begin
        gate_w[0] = ((~(op_a_w[0] & op_b_w[0]) & ~sa0[0]) | sa1[0]) ^ corr0[{op_a_w[0], op_b_w[0]}];
        gate_w[1] = ((~(op_a_w[1] & op_b_w[1]) & ~sa0[1]) | sa1[1]) ^ corr1[{op_a_w[1], op_b_w[1]}];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_fault(input int s, input logic [W-1:0] m0, input logic [W-1:0] m1,
                             input int rate);
        sa0[s] = m0;
        sa1[s] = m1;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] f;
            f = (rate > 0 && $urandom_range(rate - 1) == 0) ? W'($urandom) : '0;
            if (s == 0) corr0[i] = f; else corr1[i] = f;
        end
    endtask

    // Reference: walk all vectors, count wrong responses, note the first one.
    task automatic model(input int s, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] a, b, good, got;
            a = W'(i >> W);
            b = W'(i);
            good = ~(a & b);
            got = ((good & ~sa0[s]) | sa1[s]) ^ ((s == 0) ? corr0[i] : corr1[i]);
            if (got != good) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic run_sweep(input int s, input bit restarts, input string tag);
        int cnt, first, lat, seen;
        model(s, cnt, first);
        lat = N * (((s == 0) ? 2 : 0) + 2) + 1;
        @(negedge clk) start[s] = 1'b1;
        @(posedge clk);
        #1 start[s] = 1'b0;
        chk({tag, " busy@start"}, busy_w[s], 1'b1);
        seen = 0;
        for (int k = 1; k <= lat + 20 && seen == 0; k++) begin
            @(posedge clk);
            #1;
            start[s] = 1'b0;
            if (done_w[s]) seen = k;
            else if (restarts && (k == 10 || k == 500 || k == lat - 1)) start[s] = 1'b1;
        end
        chk({tag, " done_cycle"}, seen, lat);
        chk({tag, " err_count"}, errc_w[s], cnt);
        chk({tag, " pass"}, pass_w[s], cnt == 0);
        chk({tag, " busy@done"}, busy_w[s], 1'b0);
        chk({tag, " op_last"}, {op_a_w[s], op_b_w[s]}, 8'hFF);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk({tag, " fail_valid"}, fvalid_w[s], cnt > 0);
        chk({tag, " fail_vec"}, fvec_w[s], (cnt > 0) ? first : 0);
`else
        chk({tag, " fail_valid"}, fvalid_w[s], 1'b0);
        chk({tag, " fail_vec"}, fvec_w[s], 0);
`endif
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, done_w[s], 1'b0);
        chk({tag, " no_restart"}, busy_w[s], 1'b0);
        chk({tag, " pass_hold"}, pass_w[s], cnt == 0);
    endtask

    task automatic check_reset_state(input int s, input string tag);
        chk({tag, " rst op"}, {op_a_w[s], op_b_w[s]}, 0);
        chk({tag, " rst flags"}, {busy_w[s], done_w[s], pass_w[s], fvalid_w[s]}, 0);
        chk({tag, " rst err"}, errc_w[s], 0);
        chk({tag, " rst fvec"}, fvec_w[s], 0);
    endtask

    initial begin
        set_fault(0, '0, '0, 0);
        set_fault(1, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1 check_reset_state(0, "init0");
        check_reset_state(1, "init1");
        @(negedge clk) rst = 1'b0;

        run_sweep(0, 0, "T1");
        set_fault(0, 4'h1, 4'h0, 0);
        run_sweep(0, 0, "T2");
        set_fault(0, 4'h0, 4'h8, 0);
        run_sweep(0, 0, "T3");
        set_fault(0, '0, '0, 0);
        run_sweep(0, 1, "T4");

        // Reset mid-sweep with the T2 fault, then a clean rerun from idx 0.
        set_fault(0, 4'h1, 4'h0, 0);
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_state(0, "T5");
        repeat (2) @(posedge clk);
        #1 chk("T5 no_done", done_w[0], 1'b0);
        @(negedge clk) rst = 1'b0;
        run_sweep(0, 0, "T5run");

        for (int r = 0; r < 3; r++) begin
            set_fault(0, W'($urandom_range(1) ? $urandom : 0), '0, 16);
            run_sweep(0, 0, $sformatf("R0_%0d", r));
        end

        set_fault(1, '0, '0, 0);
        run_sweep(1, 0, "T6");
        for (int r = 0; r < 2; r++) begin
            set_fault(1, '0, W'($urandom_range(1) ? $urandom : 0), 8);
            run_sweep(1, r == 1, $sformatf("R1_%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
